// File: rtl/sem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sem_pkg : shared constants and helpers for the SEM error logger   |
// | Rev 1.0 : initial release                                         |
// +------------------------------------------------------------------+
package sem_pkg;

  localparam int FAR_W_DFLT     = 24;
  localparam int ENT_MULTI      = FAR_W_DFLT;
  localparam int ENT_UNCORR     = FAR_W_DFLT + 1;
  localparam int HIST_MODE_DROP = 0;
  localparam int HIST_MODE_OVWR = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sem_hist_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sem_hist_fifo : show-ahead circular history buffer with drop or   |
// |                 overwrite-oldest full policy and sticky overflow  |
// | Rev 1.0 : initial release                                         |
// +------------------------------------------------------------------+
module sem_hist_fifo
  import sem_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 26,
  parameter int MODE  = HIST_MODE_DROP,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             CLK40,
  input  logic             RST,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic [CNT_W-1:0] count,
  output logic             ovfl
);

  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
  localparam bit               C_OVWR  = (MODE == HIST_MODE_OVWR);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ovfl;

  logic             w_pop_eff;
  logic [CNT_W-1:0] w_count_after_pop;
  logic             w_full_after_pop;
  logic             w_drop;
  logic             w_ovwr;
  logic             w_wr_en;

  // Pop is resolved first so a full buffer with pop+push simply rotates.
  assign w_pop_eff         = pop & (r_count != '0);
  assign w_count_after_pop = r_count - CNT_W'(w_pop_eff);
  assign w_full_after_pop  = (w_count_after_pop == C_DEPTH);
  assign w_drop            = push & w_full_after_pop & ~C_OVWR;
  assign w_ovwr            = push & w_full_after_pop & C_OVWR;
  assign w_wr_en           = push & ~clr & ~w_drop;

  always_ff @(posedge CLK40 or posedge RST) begin
    if (RST) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovfl   <= 1'b0;
    end else if (clr) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovfl   <= 1'b0;
    end else begin
      if (w_wr_en)              r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_eff || w_ovwr)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_wr_en && !w_full_after_pop)
        r_count <= w_count_after_pop + CNT_W'(1);
      else
        r_count <= w_count_after_pop;
      if (push && w_full_after_pop) r_ovfl <= 1'b1;
    end
  end

  always_ff @(posedge CLK40) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= wdata;
  end

  assign valid = (r_count != '0);
  assign rdata = valid ? r_mem[r_rd_ptr] : '0;
  assign count = r_count;
  assign ovfl  = r_ovfl;

endmodule
`default_nettype wire

// File: rtl/sem_err_logger.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sem_err_logger : SEM error counters, sticky multi-bit flag, last  |
// |                  multi-bit FAR and FAR event history             |
// | Rev 1.0 : initial release                                         |
// +------------------------------------------------------------------+
module sem_err_logger
  import sem_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int SAT_CNT    = 1,
  parameter int HIST_DEPTH = 16,
  parameter int HIST_MODE  = HIST_MODE_DROP,
  parameter int FAR_W      = FAR_W_DFLT
) (
  input  logic                         CLK40,
  input  logic                         RST,
  input  logic                         FECC_ECCERR,
  input  logic                         FECC_ECCERRSINGLE,
  input  logic                         FECC_CRCERR,
  input  logic [FAR_W-1:0]             FECC_FAR,
  input  logic                         STATUS_CORRECTION,
  input  logic                         STATUS_UNCORRECTABLE,
  input  logic                         JTAG_RST_SEM_CNTRS,
  input  logic                         JTAG_DED_RST,
  input  logic                         HIST_POP,
  output logic [CNT_W-1:0]             SNGL_CNT,
  output logic [CNT_W-1:0]             MULTI_CNT,
  output logic [CNT_W-1:0]             CRC_CNT,
  output logic                         DBL_ERR_DET,
  output logic [FAR_W-1:0]             LAST_FAR,
  output logic [FAR_W+1:0]             HIST_DATA,
  output logic                         HIST_VALID,
  output logic [clog2(HIST_DEPTH):0]   HIST_COUNT,
  output logic                         HIST_OVFL
);

  logic                   r_ecc;
  logic                   r_crc;
  logic                   r_dbl;
  logic [FAR_W-1:0]       r_last_far;

  logic                   w_le_ecc;
  logic                   w_le_crc;
  logic                   w_sngl_ev;
  logic                   w_multi_ev;
  logic [2:0]             w_ev;
  logic [2:0][CNT_W-1:0]  w_cnt;

  assign w_le_ecc   = FECC_ECCERR & ~r_ecc;
  assign w_le_crc   = FECC_CRCERR & ~r_crc;
  assign w_sngl_ev  = w_le_ecc & FECC_ECCERRSINGLE & STATUS_CORRECTION;
  assign w_multi_ev = w_le_ecc & ~FECC_ECCERRSINGLE;
  assign w_ev       = {w_le_crc, w_multi_ev, w_sngl_ev};

  always_ff @(posedge CLK40 or posedge RST) begin
    if (RST) begin
      r_ecc      <= 1'b0;
      r_crc      <= 1'b0;
      r_dbl      <= 1'b0;
      r_last_far <= '0;
    end else begin
      r_ecc <= FECC_ECCERR;
      r_crc <= FECC_CRCERR;
      // A new multi-bit error outranks a same-cycle clear request.
      if (w_multi_ev)        r_dbl <= 1'b1;
      else if (JTAG_DED_RST) r_dbl <= 1'b0;
      if (w_multi_ev)        r_last_far <= FECC_FAR;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK40 or posedge RST) begin
      if (RST) begin
        r_cnt <= '0;
      end else if (JTAG_RST_SEM_CNTRS) begin
        r_cnt <= '0;
      end else if (w_ev[gi]) begin
        if (SAT_CNT == 0 || r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign w_cnt[gi] = r_cnt;
  end

  sem_hist_fifo #(
    .DEPTH (HIST_DEPTH),
    .WIDTH (FAR_W + 2),
    .MODE  (HIST_MODE)
  ) u_hist (
    .CLK40 (CLK40),
    .RST   (RST),
    .clr   (JTAG_RST_SEM_CNTRS),
    .push  (w_sngl_ev | w_multi_ev),
    .pop   (HIST_POP),
    .wdata ({STATUS_UNCORRECTABLE, w_multi_ev, FECC_FAR}),
    .rdata (HIST_DATA),
    .valid (HIST_VALID),
    .count (HIST_COUNT),
    .ovfl  (HIST_OVFL)
  );

  assign SNGL_CNT    = w_cnt[0];
  assign MULTI_CNT   = w_cnt[1];
  assign CRC_CNT     = w_cnt[2];
  assign DBL_ERR_DET = r_dbl;
  assign LAST_FAR    = r_last_far;

endmodule
`default_nettype wire
